// File: rtl/pipe_skid_barrier_if.sv
// pipe_skid_barrier_if: valid/ready handshake bundle for both sides of the skid barrier.
interface pipe_skid_barrier_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       level;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );
endinterface

// File: rtl/pipe_skid_barrier.sv
// pipe_skid_barrier: two-entry skid buffer with fully registered ready/valid.
// Optional flush is compiled in by defining PIPE_SKID_BARRIER_FLUSH_EN.
module pipe_skid_barrier #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input logic               clk,
    input logic               reset,
    input logic               flush,
    pipe_skid_barrier_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] main_q, skid_q;
    logic in_ready, out_valid, in_fire, out_fire, do_flush;
`ifdef PIPE_SKID_BARRIER_FLUSH_EN
    assign do_flush = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign do_flush = 1'b0;
`endif
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid & bus.out_ready;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= EMPTY;
        else       state <= state_next;
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   state_next = in_fire ? BUSY : EMPTY;
            BUSY:    state_next = (in_fire && !out_fire) ? FULL :
                                  (!in_fire && out_fire) ? EMPTY : BUSY;
            FULL:    state_next = out_fire ? BUSY : FULL;
            default: state_next = EMPTY;
        endcase
        if (do_flush) state_next = EMPTY;
    end
    always_comb begin
        in_ready      = state != FULL;
        out_valid     = state != EMPTY;
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_data  = main_q;
        bus.level     = state == FULL ? 2'd2 : state == BUSY ? 2'd1 : 2'd0;
    end
    // Main takes fresh input only when it is (or is becoming) free; otherwise input parks in skid.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            main_q <= RESET_DATA;
            skid_q <= RESET_DATA;
        end else if (do_flush) begin
            main_q <= RESET_DATA;
            skid_q <= RESET_DATA;
        end else begin
            if (in_fire && (state == EMPTY || out_fire)) main_q <= bus.in_data;
            else if (state == FULL && out_fire)          main_q <= skid_q;
            if (in_fire && state == BUSY && !out_fire)   skid_q <= bus.in_data;
        end
endmodule

// File: doc/pipe_skid_barrier.md
PIPE_SKID_BARRIER -- requirements
Module: pipe_skid_barrier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning payload width in bits (16 = one lc3b_word).
REQ-002 SHALL have parameter RESET_DATA, default all zeros, meaning the value loaded into both payload registers on reset and on flush.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port flush  input  1  discard all held entries (active only under the flush macro, see Configuration).
REQ-006 SHALL have port in_valid  input  1  upstream stage presents a beat.
REQ-007 SHALL have port in_ready  output  1  barrier can accept a beat this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  the barrier holds a beat for downstream.
REQ-010 SHALL have port out_ready  input  1  downstream stage takes the beat.
REQ-011 SHALL have port out_data  output  WIDTH  oldest held payload.
REQ-012 SHALL have port level  output  2  number of held entries (0, 1 or 2).

Function
REQ-013 SHALL accept an input beat when in_valid and in_ready are both 1 on a rising clk edge; it SHALL deliver an output beat when out_valid and out_ready are both 1 on a rising clk edge.
REQ-014 SHALL implement a three-state FSM with states EMPTY (level 0), BUSY (level 1, main register full) and FULL (level 2, main and skid registers full).
REQ-015 SHALL drive in_ready, out_valid and level purely from registered state: in_ready = (state != FULL), out_valid = (state != EMPTY); there SHALL be no combinational path from out_ready to in_ready.
REQ-016 SHALL drive out_data from the main register only; out_data SHALL hold steady while out_valid=1 and out_ready=0.
REQ-017 SHALL transition from EMPTY to BUSY on an input beat, loading main <= in_data; with no input beat it SHALL stay in EMPTY.
REQ-018 In BUSY, SHALL behave as follows:
- input and output beats together: stay BUSY, main <= in_data;
- input beat only: go to FULL, skid <= in_data;
- output beat only: go to EMPTY;
- neither: hold.
REQ-019 In FULL, an output beat SHALL move the barrier to BUSY with main <= skid; with no output beat it SHALL hold; no input beat is possible in FULL.
REQ-020 SHALL give a latency of exactly 1 cycle from an input beat to out_valid=1 when entering from EMPTY, and SHALL sustain 1 beat per cycle when out_ready is held at 1.
REQ-021 SHALL preserve order, and SHALL neither drop nor duplicate any beat absent flush or reset.
REQ-022 SHALL treat in_data and out_ready as don't-care when their respective valid is 0.
REQ-023 When the flush macro is defined, flush=1 SHALL take priority over all FSM transitions:
- next state is EMPTY and both registers load RESET_DATA;
- any input or output beat in that cycle is discarded from the barrier's view, though upstream still sees the in_ready it observed.

Reset
REQ-024 Asserting reset SHALL immediately, regardless of clk, force state EMPTY, main = skid = RESET_DATA, in_ready=1, out_valid=0, level=0 and out_data=RESET_DATA.
REQ-025 Reset asserted mid-transfer, including in FULL, SHALL discard both held entries; the first edge after deassertion SHALL behave as EMPTY.

Configuration
REQ-026 Macro PIPE_SKID_BARRIER_FLUSH_EN SHALL compile in the flush behaviour of REQ-023.
REQ-027 Without PIPE_SKID_BARRIER_FLUSH_EN, the flush port SHALL remain present but be ignored, and no flush logic SHALL be synthesised.

Verification
REQ-028 Reset with WIDTH=16, RESET_DATA=16'h0000 -> out_valid=0, in_ready=1, level=0, out_data=16'h0000 before the first clk edge.
REQ-029 With out_ready=1, stream 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> out_data shows the same values on the three following cycles, level stays 1, in_ready stays 1.
REQ-030 With out_ready=0, send 16'hAAAA then 16'hBBBB -> level=2, in_ready=0; raise out_ready -> 16'hAAAA then 16'hBBBB emerge on consecutive cycles, level returns to 0.
REQ-031 In FULL, hold in_valid=1 with 16'hCCCC and pulse out_ready for one cycle -> 16'hCCCC accepted only after in_ready returns to 1, with no loss or duplication.
REQ-032 With PIPE_SKID_BARRIER_FLUSH_EN, in FULL, assert flush together with in_valid=1 -> next cycle level=0, out_valid=0, and the flushed input never appears; without the macro the same stimulus leaves the held contents intact.
REQ-033 Assert reset asynchronously between edges while level=2 -> out_valid drops to 0 before the next edge, and the first beat after release appears with 1-cycle latency.
